l2_bank_arb: RTL and testbench
==============================

L2_BANK_ARB -- requirements
Module: l2_bank_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, SRAM word width (power of 2, >=8).
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports a_req_i/b_req_i  input  1  port A/B request.
REQ-007 SHALL have ports a_gnt_o/b_gnt_o  output  1  port A/B grant (combinational from req).
REQ-008 SHALL have ports a_addr_i/b_addr_i  input  ADDR_WIDTH  word address.
REQ-009 SHALL have ports a_we_i/b_we_i  input  1  1=write, 0=read.
REQ-010 SHALL have ports a_wdata_i/b_wdata_i  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports a_be_i/b_be_i  input  BE_WIDTH  byte enables.
REQ-012 SHALL have ports a_rvalid_o/b_rvalid_o  output  1  response valid, reads and writes.
REQ-013 SHALL have ports a_rdata_o/b_rdata_o  output  DATA_WIDTH  read data.
REQ-014 SHALL have ports sram_req_o, sram_we_o  output  1  SRAM request, write enable.
REQ-015 SHALL have ports sram_addr_o  output  ADDR_WIDTH; sram_wdata_o  output  DATA_WIDTH; sram_be_o  output  BE_WIDTH.
REQ-016 SHALL have port sram_rdata_i  input  DATA_WIDTH  SRAM read data, valid 1 cycle after accepted read.

Function
REQ-017 SHALL grant at most one port per cycle; a request is accepted when req && gnt are high in the same cycle.
REQ-018 SHALL grant the sole requester immediately when only one port requests.
REQ-019 SHALL on simultaneous requests grant the port not granted in the most recent conflict (round-robin pointer); pointer updates only on a conflict cycle.
REQ-020 SHALL drive sram_req_o = a_gnt_o | b_gnt_o and mux addr/we/wdata/be from the granted port combinationally (zero added latency to SRAM).
REQ-021 SHALL drive sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o to zero when no grant.
REQ-022 SHALL return response for an accepted request exactly 2 cycles after acceptance (cycle N accept, cycle N+2 rvalid), matching MEM_LATENCY 2 upstream.
REQ-023 SHALL register sram_rdata_i in cycle N+1 into a response register; rdata_o of the owning port shows that value in cycle N+2.
REQ-024 SHALL pipeline a 2-stage valid/port-id/we tag so back-to-back accepts every cycle produce back-to-back responses, in order, with no bubble.
REQ-025 SHALL assert rvalid for writes as well; rdata_o of a write response SHALL be zero.
REQ-026 SHALL hold a_rdata_o/b_rdata_o at zero in cycles where that port's rvalid is low.
REQ-027 SHALL never assert a_rvalid_o and b_rvalid_o in the same cycle.
REQ-028 SHALL not require a requester to hold req after grant; a denied request may be withdrawn without effect.
REQ-029 SHALL guarantee a continuously requesting port is granted within 2 cycles (no starvation).

Reset
REQ-030 SHALL on rst_ni low clear round-robin pointer (next conflict grants A), tag pipeline valids and response register, asynchronously.
REQ-031 SHALL drive all rvalid/rdata outputs to zero during reset; grant/SRAM outputs follow req inputs combinationally.
REQ-032 SHALL drop in-flight responses when reset asserts mid-operation; no rvalid after release for pre-reset requests.

Verification
REQ-033 A write addr 0x10 data 0xDEADBEEF_01234567 be 0xFF cycle 0; A read 0x10 cycle 1 -> a_rvalid cycle 2 (rdata 0), a_rvalid cycle 3 rdata 0xDEADBEEF_01234567.
REQ-034 A and B read every cycle for 8 cycles after reset -> grants A,B,A,B,...; responses alternate A,B from cycle 2; each port 4 responses.
REQ-035 A write be 0x0F data all-ones to zeroed word, then read -> rdata 0x00000000_FFFFFFFF.
REQ-036 B alone reads 0x3FFF four consecutive cycles -> b_gnt every cycle, 4 consecutive b_rvalid cycles 2-5, a_rvalid never.
REQ-037 Reads accepted cycles 0 and 1, rst_ni low in cycle 2 for 1 cycle -> no rvalid in cycles 2-6; pointer reset so next conflict grants A.
REQ-038 Random A/B traffic vs golden memory model 10k cycles -> all read data match, latency exactly 2, no starvation beyond 2 cycles.

Source files
------------

// File: rtl/l2_bank_arb_if.sv
// l2_bank_arb_if: port A/B request/response bus and SRAM bank bus for l2_bank_arb
//   slave  : arbiter side (takes requests, drives grants/responses and the SRAM command)
//   master : requester/SRAM side (drives requests and sram_rdata_i)
interface l2_bank_arb_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  a_req_i, b_req_i;
  logic                  a_gnt_o, b_gnt_o;
  logic [ADDR_WIDTH-1:0] a_addr_i, b_addr_i;
  logic                  a_we_i, b_we_i;
  logic [DATA_WIDTH-1:0] a_wdata_i, b_wdata_i;
  logic [BE_WIDTH-1:0]   a_be_i, b_be_i;
  logic                  a_rvalid_o, b_rvalid_o;
  logic [DATA_WIDTH-1:0] a_rdata_o, b_rdata_o;
  logic                  sram_req_o, sram_we_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic [BE_WIDTH-1:0]   sram_be_o;
  logic [DATA_WIDTH-1:0] sram_rdata_i;
  modport slave (
    input  a_req_i, b_req_i, a_addr_i, b_addr_i, a_we_i, b_we_i,
    input  a_wdata_i, b_wdata_i, a_be_i, b_be_i, sram_rdata_i,
    output a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_rdata_o, b_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
  modport master (
    output a_req_i, b_req_i, a_addr_i, b_addr_i, a_we_i, b_we_i,
    output a_wdata_i, b_wdata_i, a_be_i, b_be_i, sram_rdata_i,
    input  a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_rdata_o, b_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/l2_bank_arb.sv
// l2_bank_arb: two-port round-robin arbiter in front of one single-port L2 SRAM bank
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : A/B req/gnt/addr/we/wdata/be in, rvalid/rdata out (2-cycle response),
//                   SRAM req/we/addr/wdata/be out, sram_rdata_i in (1 cycle after read)
module l2_bank_arb #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  l2_bank_arb_if.slave  bus
);
  // ptr_q set means the next conflict goes to B
  logic                  ptr_q, ptr_d;
  logic                  v1_q, v1_d, id1_q, id1_d, we1_q, we1_d;
  logic                  v2_q, v2_d, id2_q, id2_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  assign bus.a_gnt_o      = bus.a_req_i & (~bus.b_req_i | ~ptr_q);
  assign bus.b_gnt_o      = bus.b_req_i & ~bus.a_gnt_o;
  assign bus.sram_req_o   = bus.a_gnt_o | bus.b_gnt_o;
  assign bus.sram_we_o    = bus.a_gnt_o ? bus.a_we_i : bus.b_gnt_o & bus.b_we_i;
  assign bus.sram_addr_o  = bus.a_gnt_o ? bus.a_addr_i  : bus.b_gnt_o ? bus.b_addr_i  : '0;
  assign bus.sram_wdata_o = bus.a_gnt_o ? bus.a_wdata_i : bus.b_gnt_o ? bus.b_wdata_i : '0;
  assign bus.sram_be_o    = bus.a_gnt_o ? bus.a_be_i    : bus.b_gnt_o ? bus.b_be_i    : '0;
  assign bus.a_rvalid_o   = v2_q & ~id2_q;
  assign bus.b_rvalid_o   = v2_q & id2_q;
  assign bus.a_rdata_o    = bus.a_rvalid_o ? rdata_q : '0;
  assign bus.b_rdata_o    = bus.b_rvalid_o ? rdata_q : '0;
  always_comb begin
    ptr_d   = (bus.a_req_i & bus.b_req_i) ? bus.a_gnt_o : ptr_q;
    v1_d    = bus.sram_req_o;
    id1_d   = bus.b_gnt_o;
    we1_d   = bus.sram_we_o;
    v2_d    = v1_q;
    id2_d   = id1_q;
    // write responses and idle cycles carry zero data
    rdata_d = (v1_q & ~we1_q) ? bus.sram_rdata_i : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= 1'b0;
      v1_q    <= 1'b0;
      id1_q   <= 1'b0;
      we1_q   <= 1'b0;
      v2_q    <= 1'b0;
      id2_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      v1_q    <= v1_d;
      id1_q   <= id1_d;
      we1_q   <= we1_d;
      v2_q    <= v2_d;
      id2_q   <= id2_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_l2_bank_arb.sv
// tb_l2_bank_arb: random and directed traffic on both ports checked against a golden memory model
module tb_l2_bank_arb;
  typedef struct {
    bit        req;
    bit [13:0] addr;
    bit        we;
    bit [63:0] wd;
    bit [7:0]  be;
  } pr_t;
  typedef struct {
    int        due;
    bit        port;
    bit [63:0] data;
  } rsp_t;
  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  bit [63:0] sram_mem [16384];
  bit [63:0] gmem [16384];
  rsp_t      q[$];
  bit        rr;
  int        cyc, wa, wb, nvec, nfail, cnt_av, cnt_bv;
  logic      obs_av, obs_bv, obs_ag, obs_bg;
  logic [63:0] obs_ad, obs_bd;
  l2_bank_arb_if #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .BE_WIDTH(8)) bus ();
  l2_bank_arb #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .BE_WIDTH(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic bit [63:0] merge(input bit [63:0] old, input bit [63:0] nw, input bit [7:0] be);
    for (int k = 0; k < 8; k++) if (be[k]) old[8*k +: 8] = nw[8*k +: 8];
    return old;
  endfunction
  always @(posedge clk) begin
    if (bus.sram_req_o && bus.sram_we_o)
      sram_mem[bus.sram_addr_o] <= merge(sram_mem[bus.sram_addr_o], bus.sram_wdata_o, bus.sram_be_o);
    bus.sram_rdata_i <= (bus.sram_req_o && !bus.sram_we_o) ? sram_mem[bus.sram_addr_o] : {$urandom, $urandom};
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic pr_t idle();
    pr_t p = '{default: 0};
    return p;
  endfunction
  function automatic pr_t rd(input bit [13:0] addr);
    pr_t p = '{default: 0};
    p.req = 1; p.addr = addr;
    return p;
  endfunction
  function automatic pr_t wr(input bit [13:0] addr, input bit [63:0] wd, input bit [7:0] be);
    pr_t p = '{default: 0};
    p.req = 1; p.addr = addr; p.we = 1; p.wd = wd; p.be = be;
    return p;
  endfunction
  function automatic pr_t rnd();
    pr_t p;
    p.req  = $urandom_range(0, 3) != 0;
    p.addr = 14'($urandom_range(0, 15));
    p.we   = $urandom_range(0, 1) == 1;
    p.wd   = {$urandom, $urandom};
    p.be   = 8'($urandom);
    return p;
  endfunction
  task automatic drive(input pr_t a, input pr_t b);
    bus.a_req_i = a.req; bus.a_addr_i = a.addr; bus.a_we_i = a.we; bus.a_wdata_i = a.wd; bus.a_be_i = a.be;
    bus.b_req_i = b.req; bus.b_addr_i = b.addr; bus.b_we_i = b.we; bus.b_wdata_i = b.wd; bus.b_be_i = b.be;
  endtask
  task automatic step(input pr_t a, input pr_t b);
    bit   ga, gb, ev_a, ev_b;
    pr_t  g;
    rsp_t e;
    bit [63:0] ed;
    drive(a, b);
    #2;
    if (a.req && b.req) begin
      ga = !rr; gb = rr;
    end else begin
      ga = a.req; gb = b.req;
    end
    g = ga ? a : gb ? b : idle();
    chk("a_gnt", bus.a_gnt_o, ga);
    chk("b_gnt", bus.b_gnt_o, gb);
    chk("sram_req", bus.sram_req_o, ga | gb);
    chk("sram_we", bus.sram_we_o, g.we);
    chk("sram_addr", bus.sram_addr_o, g.addr);
    chk("sram_wdata", bus.sram_wdata_o, g.wd);
    chk("sram_be", bus.sram_be_o, g.be);
    ev_a = 0; ev_b = 0; ed = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev_a = !e.port; ev_b = e.port; ed = e.data;
    end
    chk("a_rvalid", bus.a_rvalid_o, ev_a);
    chk("b_rvalid", bus.b_rvalid_o, ev_b);
    chk("a_rdata", bus.a_rdata_o, ev_a ? ed : 64'd0);
    chk("b_rdata", bus.b_rdata_o, ev_b ? ed : 64'd0);
    obs_av = bus.a_rvalid_o; obs_bv = bus.b_rvalid_o; obs_ad = bus.a_rdata_o; obs_bd = bus.b_rdata_o;
    obs_ag = bus.a_gnt_o; obs_bg = bus.b_gnt_o;
    cnt_av += int'(bus.a_rvalid_o === 1'b1);
    cnt_bv += int'(bus.b_rvalid_o === 1'b1);
    wa = (a.req && bus.a_gnt_o !== 1'b1) ? wa + 1 : 0;
    wb = (b.req && bus.b_gnt_o !== 1'b1) ? wb + 1 : 0;
    chk("a_wait_lt2", wa < 2, 1);
    chk("b_wait_lt2", wb < 2, 1);
    if (ga || gb) begin
      q.push_back('{due: cyc + 2, port: gb, data: g.we ? 64'd0 : gmem[g.addr]});
      if (g.we) gmem[g.addr] = merge(gmem[g.addr], g.wd, g.be);
    end
    if (a.req && b.req) rr = ga;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset(input int n);
    drive(idle(), idle());
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_rvalid", bus.a_rvalid_o, 0);
    chk("rst_b_rvalid", bus.b_rvalid_o, 0);
    chk("rst_a_rdata", bus.a_rdata_o, 0);
    chk("rst_b_rdata", bus.b_rdata_o, 0);
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    rr = 0; wa = 0; wb = 0;
    cyc++;
  endtask
  initial begin
    drive(idle(), idle());
    do_reset(2);
    // write then read back the same word from A
    step(wr(14'h10, 64'hDEADBEEF_01234567, 8'hFF), idle());
    step(rd(14'h10), idle());
    step(idle(), idle());
    chk("t1_wr_rvalid", obs_av, 1);
    chk("t1_wr_rdata", obs_ad, 0);
    step(idle(), idle());
    chk("t1_rd_rvalid", obs_av, 1);
    chk("t1_rd_rdata", obs_ad, 64'hDEADBEEF_01234567);
    // both ports read every cycle: strict alternation starting with A
    do_reset(1);
    cnt_av = 0; cnt_bv = 0;
    for (int i = 0; i < 8; i++) begin
      step(rd(14'(i)), rd(14'(i + 100)));
      chk("t2_a_gnt", obs_ag, (i % 2) == 0);
      chk("t2_a_rv", obs_av, i >= 2 && (i % 2) == 0);
      chk("t2_b_rv", obs_bv, i >= 2 && (i % 2) == 1);
    end
    step(idle(), idle());
    step(idle(), idle());
    chk("t2_a_count", cnt_av, 4);
    chk("t2_b_count", cnt_bv, 4);
    // partial byte-enable write into a zeroed word
    step(wr(14'h20, 64'hFFFFFFFF_FFFFFFFF, 8'h0F), idle());
    step(rd(14'h20), idle());
    step(idle(), idle());
    step(idle(), idle());
    chk("t3_be_rdata", obs_ad, 64'h00000000_FFFFFFFF);
    // B alone streams reads at the top address
    cnt_av = 0; cnt_bv = 0;
    for (int i = 0; i < 4; i++) begin
      step(idle(), rd(14'h3FFF));
      chk("t4_b_gnt", obs_bg, 1);
    end
    step(idle(), idle());
    step(idle(), idle());
    chk("t4_b_count", cnt_bv, 4);
    chk("t4_a_count", cnt_av, 0);
    // reset with reads in flight drops them and rewinds the pointer
    do_reset(1);
    step(rd(14'h10), rd(14'h11));
    step(idle(), rd(14'h12));
    do_reset(1);
    cnt_av = 0; cnt_bv = 0;
    for (int i = 0; i < 4; i++) step(idle(), idle());
    chk("t5_no_rvalid", cnt_av + cnt_bv, 0);
    step(rd(14'h1), rd(14'h2));
    chk("t5_ptr_a_gnt", obs_ag, 1);
    chk("t5_ptr_b_gnt", obs_bg, 0);
    // random traffic against the golden memory
    for (int i = 0; i < 10000; i++) step(rnd(), rnd());
    step(idle(), idle());
    step(idle(), idle());
    chk("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
